// File: rtl/lab_io_pkg.sv
// Shared types and helpers for the board push-button conditioning logic.
package lab_io_pkg;

  // Per-channel auto-repeat state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    DELAY  = 2'd2,
    REPEAT = 2'd3
  } rep_state_t;

  // Raw pin level seen when the button is not pressed.
  function automatic logic released_raw(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

  // Larger of two unsigned values, used to size the repeat counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchronizer, debounce, press/release strobes, auto-repeat.
module debounce_channel
  import lab_io_pkg::*;
#(
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 8,
  parameter int unsigned REPEAT_PERIOD   = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  input  logic i_repeat_en,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_pulse
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RMAX   = max_u(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int unsigned RCNT_W = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCNT_W-1:0] RC_DELAY  = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RC_PERIOD = RCNT_W'(REPEAT_PERIOD - 1);
  localparam logic              RELEASED  = released_raw(ACTIVE_LOW);

  logic              r_sync1;
  logic              r_sync2;
  logic              r_stable;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_press;
  logic              r_release;
  logic              r_pulse;
  rep_state_t        r_state;
  logic [RCNT_W-1:0] r_rcnt;

  logic              w_norm;
  logic              w_accept;
  logic              w_rise;
  logic              w_fall;
  rep_state_t        w_state_nxt;
  logic [RCNT_W-1:0] w_rcnt_nxt;
  logic              w_rep;

  // Normalise to 1 = pressed; a new value is accepted on the last stable count.
  assign w_norm   = r_sync2 ^ ACTIVE_LOW;
  assign w_accept = (w_norm != r_stable) && (r_cnt == CNT_LAST);
  assign w_rise   = w_accept & w_norm;
  assign w_fall   = w_accept & ~w_norm;

  // Two-flop synchronizer and debounce counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1  <= RELEASED;
      r_sync2  <= RELEASED;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      if (w_norm == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= w_norm;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Repeat FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_rcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rcnt  <= w_rcnt_nxt;
    end
  end

  // Repeat FSM next state; an accepted release wins over everything.
  always_comb begin
    w_state_nxt = r_state;
    w_rcnt_nxt  = r_rcnt;
    w_rep       = 1'b0;
    if (w_fall) begin
      w_state_nxt = IDLE;
      w_rcnt_nxt  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            if (i_repeat_en) begin
              w_state_nxt = DELAY;
              w_rcnt_nxt  = RC_DELAY;
            end else begin
              w_state_nxt = HELD;
            end
          end
        end
        HELD: begin
          w_state_nxt = HELD;
        end
        DELAY, REPEAT: begin
          if (!i_repeat_en) begin
            w_state_nxt = HELD;
          end else if (r_rcnt == '0) begin
            w_rep       = 1'b1;
            w_state_nxt = REPEAT;
            w_rcnt_nxt  = RC_PERIOD;
          end else begin
            w_rcnt_nxt = r_rcnt - RCNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_rcnt_nxt  = '0;
        end
      endcase
    end
  end

  // Registered strobes, aligned with the debounced level change.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_press   <= w_rise;
      r_release <= w_fall;
      r_pulse   <= w_rise | w_rep;
    end
  end

  assign o_level   = r_stable;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_pulse   = r_pulse;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: one independent debounce_channel per key.
module button_conditioner
  import lab_io_pkg::*;
#(
  parameter int unsigned NUM_CH          = 2,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 8,
  parameter int unsigned REPEAT_PERIOD   = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [NUM_CH-1:0] btn_in,
  input  logic [NUM_CH-1:0] repeat_en,
  output logic [NUM_CH-1:0] btn_level,
  output logic [NUM_CH-1:0] btn_press,
  output logic [NUM_CH-1:0] btn_release,
  output logic [NUM_CH-1:0] btn_pulse
);

  // Replicate the channel logic once per button.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .i_clk       (Clk),
      .i_rst       (Reset),
      .i_btn       (btn_in[g]),
      .i_repeat_en (repeat_en[g]),
      .o_level     (btn_level[g]),
      .o_press     (btn_press[g]),
      .o_release   (btn_release[g]),
      .o_pulse     (btn_pulse[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with default parameters (active-low pins).
module tb_button_conditioner;

  logic       Clk;
  logic       Reset;
  logic [1:0] btn_in;
  logic [1:0] repeat_en;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic [1:0] btn_pulse;

  int n_vec;
  int n_err;

  button_conditioner dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .btn_in      (btn_in),
    .repeat_en   (repeat_en),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_pulse   (btn_pulse)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Observed outputs as {level, press, release, pulse}, 2 bits each (ch1, ch0).
  function automatic logic [7:0] obs();
    return {btn_level, btn_press, btn_release, btn_pulse};
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (lvl,prs,rel,pul)", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then sit on the falling edge for sampling/driving.
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  logic [1:0] e_lvl, e_prs, e_rel, e_pul;

  initial begin
    n_vec = 0;
    n_err = 0;
    Reset     = 1'b1;
    btn_in    = 2'b11;
    repeat_en = 2'b00;

    // Outputs held at zero while in reset.
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq($sformatf("in_reset k=%0d", k), obs(), 8'h00);
    end
    Reset = 1'b0;

    // Idle after reset release: nothing at all for 50 cycles.
    for (int k = 1; k <= 50; k++) begin
      step();
      check_eq($sformatf("idle k=%0d", k), obs(), 8'h00);
    end

    // Press ch0 (no repeat): level/press/pulse after edge 18; then release after 18 more.
    btn_in[0] = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      e_lvl = {1'b0, (k >= 18) && (k < 38)};
      e_prs = {1'b0, k == 18};
      e_rel = {1'b0, k == 38};
      e_pul = {1'b0, k == 18};
      check_eq($sformatf("ch0_press k=%0d", k), obs(), {e_lvl, e_prs, e_rel, e_pul});
      if (k == 20) btn_in[0] = 1'b1;
    end

    // 10-cycle low glitch on ch0 must be rejected.
    btn_in[0] = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      step();
      if (k == 10) btn_in[0] = 1'b1;
      check_eq($sformatf("glitch k=%0d", k), obs(), 8'h00);
    end

    // Auto-repeat on ch1, release lands on a repeat slot and suppresses it.
    repeat_en[1] = 1'b1;
    btn_in[1]    = 1'b0;
    for (int k = 1; k <= 65; k++) begin
      step();
      e_lvl = {(k >= 18) && (k < 59), 1'b0};
      e_prs = {k == 18, 1'b0};
      e_rel = {k == 59, 1'b0};
      e_pul = {(k == 18) || ((k >= 26) && (k < 59) && (((k - 26) % 3) == 0)), 1'b0};
      check_eq($sformatf("ch1_repeat k=%0d", k), obs(), {e_lvl, e_prs, e_rel, e_pul});
      if (k == 41) btn_in[1] = 1'b1;
    end

    // Drop repeat_en five cycles after first repeat; re-raising it must not restart.
    btn_in[1] = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      step();
      e_lvl = {(k >= 18) && (k < 78), 1'b0};
      e_prs = {k == 18, 1'b0};
      e_rel = {k == 78, 1'b0};
      e_pul = {(k == 18) || (k == 26) || (k == 29), 1'b0};
      check_eq($sformatf("ch1_drop k=%0d", k), obs(), {e_lvl, e_prs, e_rel, e_pul});
      if (k == 31) repeat_en[1] = 1'b0;
      if (k == 40) repeat_en[1] = 1'b1;
      if (k == 60) btn_in[1] = 1'b1;
    end
    repeat_en = 2'b00;

    // Both channels pressed together.
    btn_in = 2'b00;
    for (int k = 1; k <= 25; k++) begin
      step();
      e_lvl = (k >= 18) ? 2'b11 : 2'b00;
      e_prs = (k == 18) ? 2'b11 : 2'b00;
      e_rel = 2'b00;
      e_pul = (k == 18) ? 2'b11 : 2'b00;
      check_eq($sformatf("both k=%0d", k), obs(), {e_lvl, e_prs, e_rel, e_pul});
    end

    // Reset mid-hold clears outputs immediately (asynchronously).
    Reset = 1'b1;
    #1;
    check_eq("async_reset", obs(), 8'h00);
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq($sformatf("hold_reset k=%0d", k), obs(), 8'h00);
    end
    Reset = 1'b0;

    // Still-held buttons re-debounce and strobe again 18 edges after reset release.
    for (int k = 1; k <= 22; k++) begin
      step();
      e_lvl = (k >= 18) ? 2'b11 : 2'b00;
      e_prs = (k == 18) ? 2'b11 : 2'b00;
      e_rel = 2'b00;
      e_pul = (k == 18) ? 2'b11 : 2'b00;
      check_eq($sformatf("re_press k=%0d", k), obs(), {e_lvl, e_prs, e_rel, e_pul});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Parametrised multi-channel conditioner for the board push-buttons that drive the SLC3 Run/Continue/Reset style controls.
- Per channel:
  - 2-flop synchronizer
  - polarity normalisation
  - counter-based debounce
  - one-cycle press and release strobes
  - optional per-channel auto-repeat for single-step Continue
- Sits between the top-level key pins and the processor control inputs. Replaces ad-hoc per-key edge logic.

Parameters:
- NUM_CH, 2, number of independent button channels.
- ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed; 0 = raw pin reads 1 when pressed.
- DEBOUNCE_CYCLES, 16, cycles a new synchronized value must stay stable before it is accepted; must be >= 1. Hardware build overrides this to 500000.
- REPEAT_DELAY, 8, cycles from the press strobe to the first repeat strobe; must be >= 1.
- REPEAT_PERIOD, 3, cycles between successive repeat strobes; must be >= 1.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- btn_in  input  NUM_CH  raw asynchronous button pins.
- repeat_en  input  NUM_CH  per-channel auto-repeat enable, synchronous to Clk.
- btn_level  output  NUM_CH  debounced level; 1 = pressed.
- btn_press  output  NUM_CH  one-cycle strobe on accepted press.
- btn_release  output  NUM_CH  one-cycle strobe on accepted release.
- btn_pulse  output  NUM_CH  one-cycle strobe on press or on each repeat.

Behaviour:
- Reset (async, active-high):
  - Synchronizer flops load the released raw value (1 if ACTIVE_LOW, else 0).
  - Debounce counters clear; stable state = released.
  - Repeat FSM = IDLE.
  - All outputs are 0.
  - No press strobe may follow reset release unless the pin is actually pressed and then debounced.
- Synchronizer: s1 <= raw, s2 <= s1. Normalised value n = s2 XOR ACTIVE_LOW.
- Debounce, per channel, counter width $clog2(DEBOUNCE_CYCLES+1):
  - If n == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= n, cnt <= 0.
  - Else: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles never changes stable.
- Latency: raw change held steady → btn_level changes after the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples the new raw value as edge 1.
- Strobes are registered and coincide with the btn_level transition cycle:
  - btn_press = stable rose.
  - btn_release = stable fell.
  - Each strobe is exactly one cycle wide.
- Repeat FSM, per channel (states IDLE, HELD, DELAY, REPEAT; rcnt width sized to max(REPEAT_DELAY, REPEAT_PERIOD)):
  - IDLE → DELAY on press if repeat_en, else IDLE → HELD on press. Entering DELAY loads rcnt = REPEAT_DELAY-1.
  - DELAY: rcnt decrements each cycle. At rcnt == 0: emit repeat, go to REPEAT, load rcnt = REPEAT_PERIOD-1.
  - REPEAT: rcnt decrements each cycle. At rcnt == 0: emit repeat, reload rcnt = REPEAT_PERIOD-1.
  - Timing: first repeat REPEAT_DELAY cycles after the press strobe; subsequent repeats every REPEAT_PERIOD cycles.
  - repeat_en low in DELAY or REPEAT → HELD; no further repeats.
  - repeat_en rising while in HELD does not restart repeating.
  - Release strobe from any state → IDLE in the same cycle; no repeat strobe in or after the release cycle.
- btn_pulse = btn_press | repeat strobe. The two never coincide.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
- Reset asserted mid-debounce or mid-repeat: immediate return to reset state. No strobe is emitted on reset assertion or deassertion.

Decomposition:
- Package lab_io_pkg:
  - enum rep_state_t {IDLE, HELD, DELAY, REPEAT}.
  - Function giving the released raw value for a given ACTIVE_LOW.
- Sub-module debounce_channel: one channel covering synchronizer, debounce, strobes and repeat FSM, with the same parameters minus NUM_CH.
- button_conditioner instantiates NUM_CH copies of debounce_channel via a generate loop.

Test Plan (defaults, ACTIVE_LOW=1):
- Reset then hold btn_in=2'b11 for 50 cycles → all outputs 0 throughout; no strobe at reset release.
- Drive btn_in[0]=0 and hold → btn_level[0] rises after edge 18; btn_press[0]=btn_pulse[0]=1 for exactly that one cycle.
- 10-cycle low glitch on btn_in[0] → btn_level[0] stays 0; no strobe.
- repeat_en[1]=1, hold btn_in[1]=0 → btn_pulse[1] at press cycle t, t+8, t+11, t+14. Release → btn_release[1] after 18 edges; no btn_pulse at or after release.
- repeat_en[1] dropped 5 cycles after the first repeat → no further btn_pulse[1] while held.
- Both channels pressed in the same cycle, then Reset pulsed mid-hold → outputs 0 immediately. After reset deassertion, the still-held buttons re-debounce and produce fresh press strobes 18 edges later.
